// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared state encoding, default sizes and round-robin helpers
// for the timer_sched block.
package timer_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned N_DEF     = 10;
  localparam int unsigned MAX_NREQ  = 8;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // First set request bit scanning ptr, ptr+1, ... modulo nreq.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                               input logic [IDX_W-1:0]    ptr,
                                               input int unsigned         nreq);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      cand = (32'(ptr) + i) % nreq;
      if (!found && (i < nreq) && req[cand[IDX_W-1:0]]) begin
        pick  = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Successor of idx modulo nreq; explicit wrap so non-power-of-two nreq works.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int unsigned      nreq);
    logic [IDX_W-1:0] nxt;
    if ((32'(idx) + 32'd1) >= nreq) nxt = '0;
    else                            nxt = IDX_W'(32'(idx) + 32'd1);
    return nxt;
  endfunction

endpackage

// File: rtl/timer_core.sv
// timer_core: shared countdown register with guarded decrement toward end_val.
module timer_core
  import timer_sched_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic         dec_en,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] end_val,
  output logic [N-1:0] count,
  output logic         at_end_c
);

  logic [N-1:0] count_d, count_q;

  // Terminal test is live against end_val; decrement only above it, so no wrap.
  always_comb begin
    at_end_c = (count_q <= end_val);
    count_d  = count_q;
    if (load_en)                   count_d = load_val;
    else if (dec_en && !at_end_c)  count_d = count_q - N'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin arbiter sharing one interval timer between NREQ
// requesters. Optional macro TIMER_SCHED_ABORT_EN: dropping req on the granted
// lane during LOAD/RUN abandons the operation without a done pulse.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned N    = N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] load_val,
  input  logic [N-1:0]      end_val,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_d, state_q;
  logic [IW-1:0]   idx_d, idx_q;
  logic [IW-1:0]   ptr_d, ptr_q;
  logic [NREQ-1:0] gnt_d, gnt_q;
  logic [NREQ-1:0] done_d, done_q;
  logic            busy_d, busy_q;
  logic            load_c, dec_c, at_end_c;
  logic [N-1:0]    lane_val_c;
  logic [IW-1:0]   pick_c, next_c;

  // Load value of the granted lane and round-robin candidates.
  always_comb begin
    lane_val_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (idx_q == IW'(i)) lane_val_c = load_val[i*N +: N];
    end
    pick_c = IW'(rr_pick(MAX_NREQ'(req), IDX_W'(ptr_q), NREQ));
    next_c = IW'(rr_next(IDX_W'(idx_q), NREQ));
  end

  // Next-state, grant, done and pointer logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    load_c  = 1'b0;
    dec_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = pick_c;
          gnt_d   = NREQ'(1) << pick_c;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (!at_end_c) begin
          dec_c = 1'b1;
        end else begin
          done_d  = NREQ'(1) << idx_q;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = next_c;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef TIMER_SCHED_ABORT_EN
    if (((state_q == LOAD) || (state_q == RUN)) && !req[idx_q]) begin
      load_c  = 1'b0;
      dec_c   = 1'b0;
      done_d  = '0;
      gnt_d   = '0;
      ptr_d   = next_c;
      state_d = IDLE;
    end
`endif
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  timer_core #(.N(N)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_c),
    .dec_en   (dec_c),
    .load_val (lane_val_c),
    .end_val  (end_val),
    .count    (count),
    .at_end_c (at_end_c)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed bench for timer_sched (NREQ=4, N=10).
module tb_timer_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned N    = 10;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] load_val;
  logic [N-1:0]      end_val;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [N-1:0]      count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  timer_sched #(.NREQ(NREQ), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .load_val (load_val),
    .end_val  (end_val),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_lv(input int lane, input int v);
    load_val[lane*N +: N] = N'(v);
  endtask

  // Step until a done pulse (bounded); gnt must hold exp_gnt every cycle.
  task automatic wait_done(input string tag, input logic [NREQ-1:0] exp_done,
                           input int exp_cyc, input logic [NREQ-1:0] exp_gnt);
    int gnt_bad;
    gnt_bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (gnt !== exp_gnt) gnt_bad++;
      if (done !== '0) break;
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_gnt_stable"}, 32'(gnt_bad), 32'd0);
  endtask

  initial begin
    int seen_done;
    rst_n    = 1'b0;
    req      = '0;
    load_val = '0;
    end_val  = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // Single request lane 0: L=10, E=3, done at cycle 10
    set_lv(0, 10);
    end_val = N'(3);
    req     = 4'b0001;
    cyc     = 0;
    step();
    chk("t1_gnt_c1", 32'(gnt), 32'h1);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    wait_done("t1", 4'b0001, 10, 4'b0001);
    chk("t1_count_at_done", 32'(count), 32'd3);
    req = '0;
    step();
    chk("t1_idle_gnt", 32'(gnt), 32'd0);
    chk("t1_idle_done", 32'(done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // L<=E on lane 2 (ptr=1 scans 1,2): done at cycle 3, count 2
    set_lv(2, 2);
    end_val = N'(5);
    req     = 4'b0100;
    cyc     = 0;
    step();
    chk("t2_gnt_c1", 32'(gnt), 32'h4);
    step();
    chk("t2_count_c2", 32'(count), 32'd2);
    wait_done("t2", 4'b0100, 3, 4'b0100);
    chk("t2_count_at_done", 32'(count), 32'd2);
    req = '0;
    step();
    chk("t2_idle_count", 32'(count), 32'd2);

    // Late arrival: lane 3 runs (ptr=3), lane 1 raised mid-RUN
    set_lv(3, 6);
    set_lv(1, 1);
    end_val = N'(0);
    req     = 4'b1000;
    cyc     = 0;
    step();
    step();
    step();
    chk("t3_gnt_run", 32'(gnt), 32'h8);
    req = 4'b1010;
    wait_done("t3a", 4'b1000, 9, 4'b1000);
    chk("t3a_count", 32'(count), 32'd0);
    req = 4'b0010;
    step();
    chk("t3_idle_gnt", 32'(gnt), 32'd0);
    cyc = 0;
    wait_done("t3b", 4'b0010, 4, 4'b0010);
    req = '0;
    step();

    // Reset mid-RUN on lane 0 (ptr=2 scans 2,3,0), L=20
    set_lv(0, 20);
    end_val = N'(0);
    req     = 4'b0001;
    cyc     = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (count == N'(5)) break;
    end
    chk("t4_count_reached", 32'(count), 32'd5);
    chk("t4_gnt_before", 32'(gnt), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_gnt", 32'(gnt), 32'd0);
    chk("t4_rst_done", 32'(done), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_count", 32'(count), 32'd0);
    req = '0;
    step();
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done !== '0 || busy !== 1'b0) seen_done++;
    end
    chk("t4_no_spurious", 32'(seen_done), 32'd0);

    // Contention: all lanes L=4 E=0, order 0,1,2,3,0 (ptr=0 after reset)
    for (int i = 0; i < 4; i++) set_lv(i, 4);
    end_val = N'(0);
    req     = 4'b1111;
    cyc     = 0;
    wait_done("t5_g0", 4'b0001, 7, 4'b0001);
    step();
    chk("t5_idle0", 32'(gnt), 32'd0);
    cyc = 0;
    wait_done("t5_g1", 4'b0010, 7, 4'b0010);
    step();
    cyc = 0;
    wait_done("t5_g2", 4'b0100, 7, 4'b0100);
    step();
    cyc = 0;
    wait_done("t5_g3", 4'b1000, 7, 4'b1000);
    step();
    cyc = 0;
    wait_done("t5_g4", 4'b0001, 7, 4'b0001);
    req = '0;
    step();
    chk("t5_end_busy", 32'(busy), 32'd0);

    // Drop req[0] during RUN (ptr=1, only lane 0 requests), L=10
    set_lv(0, 10);
    end_val = N'(0);
    req     = 4'b0001;
    cyc     = 0;
    step();
    step();
    step();
    step();
    chk("t6_count_run", 32'(count), 32'd8);
    req = '0;
`ifdef TIMER_SCHED_ABORT_EN
    step();
    chk("t6_abort_gnt", 32'(gnt), 32'd0);
    chk("t6_abort_busy", 32'(busy), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done !== '0) seen_done++;
    end
    chk("t6_abort_no_done", 32'(seen_done), 32'd0);
`else
    wait_done("t6", 4'b0001, 13, 4'b0001);
    step();
`endif
    // Either way ptr is now 1: lane 1 wins a full request
    req = 4'b1111;
    step();
    chk("t6_next_gnt", 32'(gnt), 32'h2);
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
